// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared op-code, FSM state encodings and multiplier helper for mdu_ctrl
package mdu_ctrl_pkg;

  localparam logic [2:0] OP_DIV   = 3'd0;
  localparam logic [2:0] OP_DIVU  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } mdu_state_e;

  // A 64-bit product truncated to 64 bits is exact for both signednesses
  // once the operands are sign- or zero-extended to 64 bits first.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    a_ext = {{32{is_signed & a[31]}}, a};
    b_ext = {{32{is_signed & b[31]}}, b};
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/mdu_ctrl_hilo_reg.sv
// rtl/mdu_ctrl_hilo_reg.sv - architectural HI/LO register pair with independent write enables
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= 32'd0;
      lo_o <= 32'd0;
    end else begin
      if (we_hi) hi_o <= hi_i;
      if (we_lo) lo_o <= lo_i;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit control: divider handshake FSM, multiplier and HI/LO writes
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [2:0]  op_code_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_e  state, state_nxt;
  logic        is_div;
  logic        issue;
  logic [63:0] product;
  logic        we_hi, we_lo;
  logic [31:0] hi_wdata, lo_wdata;

  assign is_div  = op_valid_i && (op_code_i == OP_DIV || op_code_i == OP_DIVU);
  assign issue   = (state == IDLE) && is_div && !flush_i;
  assign product = mul64(opdata1_i, opdata2_i, op_code_i == OP_MULT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (issue) state_nxt = DIV_WAIT;
      DIV_WAIT: begin
        if (flush_i)          state_nxt = IDLE;
        else if (div_ready_i) state_nxt = DIV_DONE;
      end
      // The DIV stays in EX while stalled; leaving only on !stall_i prevents a reissue.
      DIV_DONE: if (!stall_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stallreq_o  = 1'b0;
    div_annul_o = 1'b0;
    we_hi       = 1'b0;
    we_lo       = 1'b0;
    hi_wdata    = 32'd0;
    lo_wdata    = 32'd0;
    case (state)
      IDLE: begin
        stallreq_o  = issue;
        div_annul_o = is_div && flush_i;
        if (op_valid_i && !flush_i && !stall_i) begin
          case (op_code_i)
            OP_MULT, OP_MULTU: begin
              we_hi    = 1'b1;
              we_lo    = 1'b1;
              hi_wdata = product[63:32];
              lo_wdata = product[31:0];
            end
            OP_MTHI: begin
              we_hi    = 1'b1;
              hi_wdata = opdata1_i;
            end
            OP_MTLO: begin
              we_lo    = 1'b1;
              lo_wdata = opdata1_i;
            end
            default: ;
          endcase
        end
      end
      DIV_WAIT: begin
        stallreq_o  = 1'b1;
        div_annul_o = flush_i;
        if (div_ready_i && !flush_i) begin
          we_hi    = 1'b1;
          we_lo    = 1'b1;
          hi_wdata = div_result_i[63:32];
          lo_wdata = div_result_i[31:0];
        end
      end
      default: ;
    endcase
  end

  // div_start_o is held high until the result is taken so the divider never frees early.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_start_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= 32'd0;
      div_opdata2_o <= 32'd0;
    end else if (issue) begin
      div_start_o   <= 1'b1;
      div_signed_o  <= (op_code_i == OP_DIV);
      div_opdata1_o <= opdata1_i;
      div_opdata2_o <= opdata2_i;
    end else if (state == DIV_WAIT && (flush_i || div_ready_i)) begin
      div_start_o   <= 1'b0;
    end
  end

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .hi_i  (hi_wdata),
    .lo_i  (lo_wdata),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic [2:0]  op_code_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        flush_i, stall_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid_i    (op_valid_i),
    .op_code_i     (op_code_i),
    .opdata1_i     (opdata1_i),
    .opdata2_i     (opdata2_i),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .div_result_i  (div_result_i),
    .div_ready_i   (div_ready_i),
    .div_start_o   (div_start_o),
    .div_annul_o   (div_annul_o),
    .div_signed_o  (div_signed_o),
    .div_opdata1_o (div_opdata1_o),
    .div_opdata2_o (div_opdata2_o),
    .stallreq_o    (stallreq_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    op_valid_i = 1'b1;
    op_code_i  = code;
    opdata1_i  = a;
    opdata2_i  = b;
  endtask

  // Issue a division, wait, then return the result; ends one step into DIV_DONE.
  task automatic do_div(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int wait_cycles, input logic [63:0] res, input string tag);
    present(code, a, b);
    settle();
    chk({tag, "_stall_issue"}, {63'd0, stallreq_o}, 64'd1);
    tick();
    chk({tag, "_start"}, {63'd0, div_start_o}, 64'd1);
    for (int i = 0; i < wait_cycles; i++) tick();
    div_result_i = res;
    div_ready_i  = 1'b1;
    settle();
    chk({tag, "_stall_ready"}, {63'd0, stallreq_o}, 64'd1);
    tick();
    div_ready_i  = 1'b0;
    div_result_i = 64'd0;
  endtask

  task automatic to_idle();
    stall_i = 1'b0;
    tick();
    op_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    op_valid_i = 1'b0; op_code_i = 3'd0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    flush_i = 1'b0; stall_i = 1'b0; div_result_i = 64'd0; div_ready_i = 1'b0;
    tick(); tick();
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    chk("rst_start", {63'd0, div_start_o}, 64'd0);
    chk("rst_signed", {63'd0, div_signed_o}, 64'd0);
    chk("rst_opd", {div_opdata1_o, div_opdata2_o}, 64'd0);
    chk("rst_state", {62'd0, dut.state}, {62'd0, IDLE});
    rst = 1'b0;
    tick();

    // DIV 7 / -2
    present(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    settle();
    chk("div1_annul", {63'd0, div_annul_o}, 64'd0);
    tick();
    chk("div1_signed", {63'd0, div_signed_o}, 64'd1);
    chk("div1_opd", {div_opdata1_o, div_opdata2_o}, {32'd7, 32'hFFFF_FFFE});
    chk("div1_state_wait", {62'd0, dut.state}, {62'd0, DIV_WAIT});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("div1_stall_wait", {63'd0, stallreq_o}, 64'd1);
    end
    div_result_i = {32'h0000_0001, 32'hFFFF_FFFD};
    div_ready_i  = 1'b1;
    tick();
    div_ready_i  = 1'b0;
    chk("div1_hilo", {hi_o, lo_o}, {32'h0000_0001, 32'hFFFF_FFFD});
    chk("div1_start_done", {63'd0, div_start_o}, 64'd0);
    chk("div1_stall_done", {63'd0, stallreq_o}, 64'd0);
    chk("div1_state_done", {62'd0, dut.state}, {62'd0, DIV_DONE});
    to_idle();
    chk("div1_state_idle", {62'd0, dut.state}, {62'd0, IDLE});

    // DIVU 0xFFFFFFFF / 16
    do_div(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 2, {32'h0000_000F, 32'h0FFF_FFFF}, "divu");
    chk("divu_signed", {63'd0, div_signed_o}, 64'd0);
    chk("divu_hilo", {hi_o, lo_o}, {32'h0000_000F, 32'h0FFF_FFFF});
    to_idle();

    // DIV 5 / 0: the divider reports zero
    do_div(OP_DIV, 32'd5, 32'd0, 4, 64'd0, "div0");
    chk("div0_hilo", {hi_o, lo_o}, 64'd0);
    chk("div0_stall_after", {63'd0, stallreq_o}, 64'd0);
    to_idle();

    // Flush ten cycles into a DIV, with a stray ready in the same cycle
    present(OP_DIV, 32'd100, 32'd7);
    tick();
    for (int i = 0; i < 9; i++) tick();
    flush_i = 1'b1;
    div_ready_i = 1'b1;
    div_result_i = {32'd2, 32'd14};
    settle();
    chk("flush_annul", {63'd0, div_annul_o}, 64'd1);
    tick();
    flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'd0; op_valid_i = 1'b0;
    settle();
    chk("flush_annul_once", {63'd0, div_annul_o}, 64'd0);
    chk("flush_state", {62'd0, dut.state}, {62'd0, IDLE});
    chk("flush_hilo", {hi_o, lo_o}, 64'd0);
    chk("flush_start", {63'd0, div_start_o}, 64'd0);
    tick();
    do_div(OP_DIVU, 32'd9, 32'd3, 1, {32'd0, 32'd3}, "divu93");
    chk("divu93_hilo", {hi_o, lo_o}, {32'd0, 32'd3});
    to_idle();

    // Flush with a DIV presented in IDLE: annul, no issue
    present(OP_DIV, 32'd1, 32'd1);
    flush_i = 1'b1;
    settle();
    chk("idle_flush_annul", {63'd0, div_annul_o}, 64'd1);
    chk("idle_flush_stall", {63'd0, stallreq_o}, 64'd0);
    tick();
    flush_i = 1'b0; op_valid_i = 1'b0;
    chk("idle_flush_start", {63'd0, div_start_o}, 64'd0);
    chk("idle_flush_state", {62'd0, dut.state}, {62'd0, IDLE});

    // Multiplies and moves
    present(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    settle();
    chk("mult_stall", {63'd0, stallreq_o}, 64'd0);
    tick();
    chk("mult_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    present(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    settle();
    chk("multu_stall", {63'd0, stallreq_o}, 64'd0);
    tick();
    chk("multu_hilo", {hi_o, lo_o}, {32'h0000_0001, 32'hFFFF_FFFE});
    present(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    tick();
    chk("mthi_hilo", {hi_o, lo_o}, {32'hDEAD_BEEF, 32'hFFFF_FFFE});
    present(OP_MTLO, 32'h1234_5678, 32'd0);
    tick();
    chk("mtlo_hilo", {hi_o, lo_o}, {32'hDEAD_BEEF, 32'h1234_5678});
    present(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    stall_i = 1'b1;
    tick();
    chk("mult_stalled_hilo", {hi_o, lo_o}, {32'hDEAD_BEEF, 32'h1234_5678});
    stall_i = 1'b0;
    present(OP_MTHI, 32'hAAAA_5555, 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("mthi_flushed_hilo", {hi_o, lo_o}, {32'hDEAD_BEEF, 32'h1234_5678});
    op_valid_i = 1'b0;
    tick();

    // DIV 20 / 3 completing under a 3-cycle downstream stall
    stall_i = 1'b1;
    do_div(OP_DIV, 32'd20, 32'd3, 2, {32'd2, 32'd6}, "divst");
    chk("divst_hilo", {hi_o, lo_o}, {32'd2, 32'd6});
    for (int i = 0; i < 3; i++) begin
      chk("divst_state_held", {62'd0, dut.state}, {62'd0, DIV_DONE});
      chk("divst_start_low", {63'd0, div_start_o}, 64'd0);
      chk("divst_stall_low", {63'd0, stallreq_o}, 64'd0);
      if (i < 2) tick();
    end
    stall_i = 1'b0;
    tick();
    chk("divst_state_idle", {62'd0, dut.state}, {62'd0, IDLE});
    chk("divst_no_reissue", {63'd0, div_start_o}, 64'd0);
    op_valid_i = 1'b0;
    tick();

    // Reset mid-division abandons the op
    present(OP_DIV, 32'd50, 32'd5);
    tick();
    op_valid_i = 1'b0;
    rst = 1'b1;
    div_ready_i = 1'b1;
    div_result_i = {32'd0, 32'd10};
    tick();
    rst = 1'b0; div_ready_i = 1'b0; div_result_i = 64'd0;
    chk("rstdiv_hilo", {hi_o, lo_o}, 64'd0);
    chk("rstdiv_state", {62'd0, dut.state}, {62'd0, IDLE});
    chk("rstdiv_start", {63'd0, div_start_o}, 64'd0);
    tick();
    chk("rstdiv_hilo_after", {hi_o, lo_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset rst, synchronous, active-high.
REQ-003 op_valid_i  in  1  EX stage presents a multiply/divide-unit op this cycle.
REQ-004 op_code_i  in  3  0 DIV, 1 DIVU, 2 MULT, 3 MULTU, 4 MTHI, 5 MTLO; 6-7 ignored.
REQ-005 opdata1_i / opdata2_i  in  32 each  rs / rt operand values.
REQ-006 flush_i  in  1  pipeline flush (exception), kills the op in EX.
REQ-007 stall_i  in  1  downstream stall; EX instruction is held.
REQ-008 div_result_i  in  64  divider result: {remainder, quotient}.
REQ-009 div_ready_i  in  1  divider result valid.
REQ-010 div_start_o  out  1  divider start, registered.
REQ-011 div_annul_o  out  1  divider cancel, combinational.
REQ-012 div_signed_o  out  1  signed-division select, registered.
REQ-013 div_opdata1_o / div_opdata2_o  out  32 each  latched dividend / divisor.
REQ-014 stallreq_o  out  1  request to hold IF/ID/EX, combinational.
REQ-015 hi_o / lo_o  out  32 each  architectural HI/LO, registered.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, DIV_WAIT, DIV_DONE.
REQ-017 IDLE: on op_valid_i with DIV/DIVU and flush_i=0, the block SHALL:
- latch both operands;
- set div_signed_o = (op_code_i==DIV);
- set div_start_o=1;
- enter DIV_WAIT.
REQ-018 stallreq_o SHALL be 1 in IDLE while a non-flushed DIV/DIVU is presented, 1 throughout DIV_WAIT, and 0 in DIV_DONE and all other cases.
REQ-019 DIV_WAIT with div_ready_i=1 and flush_i=0: the block SHALL write HI<=div_result_i[63:32], LO<=div_result_i[31:0], clear div_start_o and enter DIV_DONE.
REQ-020 div_start_o SHALL stay 1 continuously from issue until the ready cycle, so the divider returns to its free state only after the result is captured.
REQ-021 DIV_DONE SHALL return to IDLE when stall_i=0 and SHALL stay in DIV_DONE while stall_i=1; the held DIV SHALL never be reissued.
REQ-022 flush_i=1 in DIV_WAIT: div_annul_o=1 that cycle; div_start_o cleared; next state IDLE; HI/LO unchanged, even if div_ready_i=1 in the same cycle.
REQ-023 div_annul_o SHALL be 0 except as defined in REQ-022 and REQ-024.
REQ-024 flush_i=1 with a DIV presented in IDLE: no issue; div_annul_o=1.
REQ-025 IDLE, op_valid_i=1, flush_i=0, stall_i=0:
- MULT: {HI,LO} <= signed 64-bit product;
- MULTU: {HI,LO} <= unsigned 64-bit product;
- MTHI: HI <= opdata1_i;
- MTLO: LO <= opdata1_i;
- the write is single-cycle with no stall.
REQ-026 MULT/MULTU/MTHI/MTLO with stall_i=1 or flush_i=1 SHALL NOT write HI/LO.
REQ-027 Division by zero SHALL have no special handling here; the divider's zero result SHALL be written as HI=LO=0.

Reset
REQ-028 rst=1 SHALL force:
- state IDLE;
- hi_o, lo_o, div_opdata1_o, div_opdata2_o = 0;
- div_start_o = div_signed_o = 0.
REQ-029 rst asserted mid-division SHALL abandon the operation with no HI/LO write; the divider resets on the same rst.

Structure
REQ-030 Op-code encodings and FSM state encodings SHALL live in the shared defines package.
REQ-031 HI/LO storage SHALL be a sub-module hilo_reg (clk, rst, we_hi, we_lo, hi_i, lo_i, hi_o, lo_o).
REQ-032 The multiplier SHALL be one combinational 32x32->64 unit with signed/unsigned select.

Verification
REQ-033 DIV 7, 0xFFFFFFFE (-2) -> LO=0xFFFFFFFD, HI=0x00000001; stallreq_o high from issue to the ready cycle, low in DIV_DONE.
REQ-034 DIVU 0xFFFFFFFF, 0x00000010 -> LO=0x0FFFFFFF, HI=0x0000000F; div_signed_o=0.
REQ-035 DIV 5, 0 -> HI=LO=0; stallreq_o releases after div_ready_i.
REQ-036 Flush 10 cycles into a DIV -> one-cycle div_annul_o, HI/LO unchanged, state IDLE; a following DIVU 9,3 gives LO=3, HI=0.
REQ-037 MULT 0xFFFFFFFD (-3), 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU 0xFFFFFFFF, 2 -> HI=1, LO=0xFFFFFFFE; stallreq_o never set.
REQ-038 DIV completes with stall_i=1 held for 3 cycles -> stays in DIV_DONE, div_start_o=0, no reissue, IDLE one cycle after stall_i falls.
